// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// One request may be outstanding; responses come back in order.
interface fetch_stage_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int INSTR_SIZE = 32
);
    logic                  req;
    logic [ADDR_SIZE-1:0]  addr;
    logic                  gnt;
    logic                  rvalid;
    logic [INSTR_SIZE-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time and feeds the
// IF/ID slot, absorbing decode stalls with a one-entry skid buffer and handling redirects.
module fetch_stage #(
    parameter int                   INSTR_SIZE = 32,
    parameter int                   ADDR_SIZE  = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_stage_if.master         imem,
    input  logic                  stall_d,
    input  logic                  brn_taken,
    input  logic [ADDR_SIZE-1:0]  brn_target,
    output logic [INSTR_SIZE-1:0] instr_d,
    output logic [ADDR_SIZE-1:0]  pc_d,
    output logic                  valid_d
);

    localparam logic [INSTR_SIZE-1:0] NOP        = INSTR_SIZE'(32'h0000_0013);
    localparam logic [ADDR_SIZE-1:0]  ALIGN_MASK = ~ADDR_SIZE'(3);
    localparam logic [ADDR_SIZE-1:0]  PC_STEP    = ADDR_SIZE'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  drop;
    logic                  drop_next;

    logic [ADDR_SIZE-1:0]  pc;
    logic [ADDR_SIZE-1:0]  req_addr;

    logic                  buf_valid;
    logic [INSTR_SIZE-1:0] buf_instr;
    logic [ADDR_SIZE-1:0]  buf_pc;

    logic                  grant;
    logic                  slot_free;
    logic                  rsp_live;
    logic                  in_flight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    // in_flight: a granted request whose response has not come back by the end of this cycle.
    always_comb begin
        imem.req   = (state == S_REQ) && !rst;
        imem.addr  = pc;
        grant      = imem.req && imem.gnt;
        slot_free  = !valid_d || !stall_d;
        rsp_live   = (state == S_WAIT) && imem.rvalid && !drop;
        in_flight  = grant || ((state == S_WAIT) && !imem.rvalid);
        state_next = state;
        drop_next  = drop;

        if (brn_taken) begin
            state_next = in_flight ? S_WAIT : S_REQ;
            drop_next  = in_flight;
        end else begin
            case (state)
                S_REQ: begin
                    if (grant) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        drop_next  = 1'b0;
                        state_next = (drop || slot_free) ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        state_next = S_REQ;
                    end
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    // The skid buffer outranks a fresh response for the slot; both cannot occur together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_valid <= 1'b0;
            buf_instr <= NOP;
            buf_pc    <= '0;
            instr_d   <= NOP;
            pc_d      <= '0;
            valid_d   <= 1'b0;
        end else if (brn_taken) begin
            pc        <= brn_target & ALIGN_MASK;
            buf_valid <= 1'b0;
            valid_d   <= 1'b0;
        end else begin
            if (grant) begin
                pc       <= pc + PC_STEP;
                req_addr <= pc;
            end

            if (buf_valid && slot_free) begin
                instr_d   <= buf_instr;
                pc_d      <= buf_pc;
                valid_d   <= 1'b1;
                buf_valid <= 1'b0;
            end else if (rsp_live && slot_free) begin
                instr_d <= imem.rdata;
                pc_d    <= req_addr;
                valid_d <= 1'b1;
            end else if (rsp_live) begin
                buf_instr <= imem.rdata;
                buf_pc    <= req_addr;
                buf_valid <= 1'b1;
            end else if (!stall_d) begin
                valid_d <= 1'b0;
            end
        end
    end

endmodule
